// File: rtl/mux2_rr_arbiter.sv
// Two requesters share one registered 2:1 mux; round-robin
// arbiter owns the select, bounded bursts prevent starvation.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   req_a, req_b   level requests, held for the whole transfer
//   a_in, b_in     mux data inputs (WIDTH)
//   gnt_a, gnt_b   registered grants, one-hot or idle
//   sel            registered mux select (0=A, 1=B)
//   x_out          registered mux output (WIDTH)
//   x_valid        x_out carries a transferred beat
module mux2_rr_arbiter #(
  parameter int WIDTH      = 1,
  parameter int MAX_BURST  = 4,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] x_out,
  output logic             x_valid
);

  localparam int CW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LIM =
    CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  // 0: A served last, 1: B served last
  logic          last;
  logic          last_nxt;
  logic          beat_a;
  logic          beat_b;
  logic          at_lim;

  assign beat_a = (state == OWN_A) && req_a;
  assign beat_b = (state == OWN_B) && req_b;
  assign at_lim = (cnt == LIM);

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    last_nxt = last;
    unique case (state)
      IDLE: begin
        if (req_a && req_b)
          nxt = last ? OWN_A : OWN_B;
        else if (req_a)
          nxt = OWN_A;
        else if (req_b)
          nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a) begin
          nxt      = req_b ? OWN_B : IDLE;
          last_nxt = 1'b0;
        end else if (at_lim && req_b) begin
          nxt      = OWN_B;
          last_nxt = 1'b0;
        end else begin
          // uncontended: window restarts
          cnt_nxt = at_lim ? '0 : cnt + 1'b1;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          nxt      = req_a ? OWN_A : IDLE;
          last_nxt = 1'b1;
        end else if (at_lim && req_a) begin
          nxt      = OWN_A;
          last_nxt = 1'b1;
        end else begin
          cnt_nxt = at_lim ? '0 : cnt + 1'b1;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
    if (nxt != state)
      cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= ~FIRST_PRIO;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      sel   <= 1'b0;
    end else begin
      gnt_a <= (nxt == OWN_A);
      gnt_b <= (nxt == OWN_B);
      // sel holds through IDLE
      if (nxt == OWN_A)
        sel <= 1'b0;
      else if (nxt == OWN_B)
        sel <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out   <= '0;
      x_valid <= 1'b0;
    end else begin
      x_valid <= beat_a || beat_b;
      if (beat_b)
        x_out <= b_in;
      else if (beat_a)
        x_out <= a_in;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter with default
// parameters (WIDTH=1, MAX_BURST=4, FIRST_PRIO=0).
module tb_mux2_rr_arbiter;

  logic clk;
  logic rst_n;
  logic req_a;
  logic req_b;
  logic [0:0] a_in;
  logic [0:0] b_in;
  logic gnt_a;
  logic gnt_b;
  logic sel;
  logic [0:0] x_out;
  logic x_valid;

  int total;
  int bad;

  mux2_rr_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .req_b   (req_b),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .x_out   (x_out),
    .x_valid (x_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    a_in  = 1'b0;
    b_in  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    do_reset();
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_gnt_b", 32'(gnt_b), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_x_out", 32'(x_out), 0);
    chk("rst_x_valid", 32'(x_valid), 0);

    // A alone, 10 beats, no forced release
    req_a = 1'b1;
    a_in  = 1'b1;
    b_in  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("solo_gnt_a_%0d", i),
          32'(gnt_a), 1);
      chk($sformatf("solo_gnt_b_%0d", i),
          32'(gnt_b), 0);
      chk($sformatf("solo_sel_%0d", i),
          32'(sel), 0);
      chk($sformatf("solo_xv_%0d", i),
          32'(x_valid), (i >= 2) ? 1 : 0);
      chk($sformatf("solo_x_%0d", i),
          32'(x_out), (i >= 2) ? 1 : 0);
    end
    req_a = 1'b0;
    step();
    chk("solo_end_gnt_a", 32'(gnt_a), 0);
    chk("solo_end_xv", 32'(x_valid), 0);
    chk("solo_end_x_hold", 32'(x_out), 1);
    chk("solo_end_sel", 32'(sel), 0);

    // contention from reset: 4 A, 4 B, back to A
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    a_in  = 1'b1;
    b_in  = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("rr_gnt_a_%0d", i), 32'(gnt_a),
          (i <= 4 || i >= 9) ? 1 : 0);
      chk($sformatf("rr_gnt_b_%0d", i), 32'(gnt_b),
          (i >= 5 && i <= 8) ? 1 : 0);
      chk($sformatf("rr_sel_%0d", i), 32'(sel),
          (i >= 5 && i <= 8) ? 1 : 0);
      chk($sformatf("rr_xv_%0d", i), 32'(x_valid),
          (i >= 2) ? 1 : 0);
      chk($sformatf("rr_x_%0d", i), 32'(x_out),
          (i < 2) ? 0 :
          (i >= 6 && i <= 9) ? 0 : 1);
    end

    // async reset mid-burst
    do_reset();
    req_a = 1'b1;
    a_in  = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_gnt_a", 32'(gnt_a), 1);
    chk("pre_rst_x", 32'(x_out), 1);
    chk("pre_rst_xv", 32'(x_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_gnt_a", 32'(gnt_a), 0);
    chk("async_gnt_b", 32'(gnt_b), 0);
    chk("async_sel", 32'(sel), 0);
    chk("async_x", 32'(x_out), 0);
    chk("async_xv", 32'(x_valid), 0);

    // handover A->B in the same cycle
    do_reset();
    req_a = 1'b1;
    a_in  = 1'b0;
    b_in  = 1'b1;
    step();
    step();
    chk("ho_gnt_a", 32'(gnt_a), 1);
    chk("ho_x_a", 32'(x_out), 0);
    chk("ho_xv_a", 32'(x_valid), 1);
    req_a = 1'b0;
    req_b = 1'b1;
    step();
    chk("ho_gnt_b", 32'(gnt_b), 1);
    chk("ho_gnt_a_off", 32'(gnt_a), 0);
    chk("ho_sel", 32'(sel), 1);
    chk("ho_xv_gap", 32'(x_valid), 0);
    step();
    chk("ho_xv_b", 32'(x_valid), 1);
    chk("ho_x_b", 32'(x_out), 1);

    // data sweep with sel=1 (B owns)
    for (int c = 0; c < 4; c++) begin
      a_in = 1'((c >> 1) & 1);
      b_in = 1'(c & 1);
      step();
      chk($sformatf("sw_b_sel_%0d", c),
          32'(sel), 1);
      chk($sformatf("sw_b_x_%0d", c),
          32'(x_out), c & 1);
    end
    // hand back to A, then sweep with sel=0
    req_b = 1'b0;
    req_a = 1'b1;
    step();
    chk("sw_ho_sel", 32'(sel), 0);
    chk("sw_ho_gnt_a", 32'(gnt_a), 1);
    for (int c = 0; c < 4; c++) begin
      a_in = 1'((c >> 1) & 1);
      b_in = 1'(c & 1);
      step();
      chk($sformatf("sw_a_sel_%0d", c),
          32'(sel), 0);
      chk($sformatf("sw_a_x_%0d", c),
          32'(x_out), (c >> 1) & 1);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
